// File: rtl/fcmp_pipe.sv
// fcmp_pipe: two-stage single-precision compare/select unit (FMAX/FMIN/FEQ/FLT/FLE), valid/ready both sides.
// Define FCMP_FCLASS_EN to add FCLASS on op 101; otherwise op 101 returns 0 like any illegal op.
module fcmp_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_nv
);

  typedef enum logic [2:0] {
    OP_FMAX   = 3'b000,
    OP_FMIN   = 3'b001,
    OP_FEQ    = 3'b010,
    OP_FLT    = 3'b011,
    OP_FLE    = 3'b100,
    OP_FCLASS = 3'b101
  } op_e;

  typedef struct packed {
    logic sign;
    logic nan;
    logic snan;
    logic zero;
    logic inf;
    logic sub;
  } fcls_t;

  localparam logic [WIDTH-1:0] CANON_NAN = WIDTH'(32'h7FC0_0000);

  function automatic fcls_t classify(input logic [WIDTH-1:0] x);
    fcls_t c;
    logic  exp_ones;
    logic  exp_zero;
    logic  frac_nz;
    exp_ones = &x[30:23];
    exp_zero = ~|x[30:23];
    frac_nz  = |x[22:0];
    c.sign   = x[31];
    c.nan    = exp_ones & frac_nz;
    c.snan   = exp_ones & frac_nz & ~x[22];
    c.zero   = exp_zero & ~frac_nz;
    c.inf    = exp_ones & ~frac_nz;
    c.sub    = exp_zero & frac_nz;
    return c;
  endfunction

  // Strict x < y for non-NaN operands; signed zeros compare equal.
  function automatic logic flt(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                               input fcls_t cx, input fcls_t cy);
    if (cx.zero && cy.zero) return 1'b0;
    if (x == y)             return 1'b0;
    if (cx.sign != cy.sign) return cx.sign;
    if (cx.sign)            return x[30:0] > y[30:0];
    return x[30:0] < y[30:0];
  endfunction

`ifdef FCMP_FCLASS_EN
  function automatic logic [9:0] fclass_mask(input fcls_t c);
    logic [9:0] m;
    logic       normal;
    m      = '0;
    normal = ~c.nan & ~c.inf & ~c.zero & ~c.sub;
    if (c.nan) begin
      m[8] = c.snan;
      m[9] = ~c.snan;
    end else if (c.sign) begin
      m[0] = c.inf;
      m[1] = normal;
      m[2] = c.sub;
      m[3] = c.zero;
    end else begin
      m[4] = c.zero;
      m[5] = c.sub;
      m[6] = normal;
      m[7] = c.inf;
    end
    return m;
  endfunction
`endif

  logic             s1_valid_q;
  logic [2:0]       s1_op_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [TAG_W-1:0] s1_tag_q;
  fcls_t            s1_ca_q;
  fcls_t            s1_cb_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_result_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic             s2_nv_q;
  logic [WIDTH-1:0] s2_result_d;
  logic             s2_nv_d;

  logic s1_en;
  logic s2_en;

  assign s2_en    = ~s2_valid_q | out_ready;
  assign s1_en    = ~s1_valid_q | s2_en;
  assign in_ready = s1_en;

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_tag    = s2_tag_q;
  assign out_nv     = s2_nv_q;

  logic any_nan;
  logic any_snan;
  logic both_zero;
  logic a_eq_b;
  logic a_lt_b;
  logic b_lt_a;
  logic is_min;

  assign any_nan   = s1_ca_q.nan | s1_cb_q.nan;
  assign any_snan  = s1_ca_q.snan | s1_cb_q.snan;
  assign both_zero = s1_ca_q.zero & s1_cb_q.zero;
  assign a_eq_b    = both_zero | (s1_a_q == s1_b_q);
  assign a_lt_b    = flt(s1_a_q, s1_b_q, s1_ca_q, s1_cb_q);
  assign b_lt_a    = flt(s1_b_q, s1_a_q, s1_cb_q, s1_ca_q);
  assign is_min    = (s1_op_q == OP_FMIN);

  // Class bits not consumed by every build configuration.
  logic unused_cls;
  assign unused_cls = &{1'b0, s1_ca_q.sub, s1_cb_q.sub, s1_cb_q.inf, s1_ca_q.inf};

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    s2_result_d = '0;
    s2_nv_d     = 1'b0;
    case (s1_op_q)
      OP_FMAX, OP_FMIN: begin
        s2_nv_d = any_snan;
        if (s1_ca_q.nan && s1_cb_q.nan)  s2_result_d = CANON_NAN;
        else if (s1_ca_q.nan)            s2_result_d = s1_b_q;
        else if (s1_cb_q.nan)            s2_result_d = s1_a_q;
        else if (both_zero)              s2_result_d = (s1_ca_q.sign == is_min) ? s1_a_q : s1_b_q;
        else if (is_min)                 s2_result_d = b_lt_a ? s1_b_q : s1_a_q;
        else                             s2_result_d = a_lt_b ? s1_b_q : s1_a_q;
      end
      OP_FEQ: begin
        s2_nv_d     = any_snan;
        s2_result_d = WIDTH'(~any_nan & a_eq_b);
      end
      OP_FLT: begin
        s2_nv_d     = any_nan;
        s2_result_d = WIDTH'(~any_nan & a_lt_b);
      end
      OP_FLE: begin
        s2_nv_d     = any_nan;
        s2_result_d = WIDTH'(~any_nan & (a_lt_b | a_eq_b));
      end
`ifdef FCMP_FCLASS_EN
      OP_FCLASS: s2_result_d = WIDTH'(fclass_mask(s1_ca_q));
`endif
      default: ;
    endcase
  end

  // NOTE: data registers are reset too, so outputs read zero after reset rather than stale values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_tag_q    <= '0;
      s1_ca_q     <= '0;
      s1_cb_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_tag_q    <= '0;
      s2_nv_q     <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_op_q  <= in_op;
          s1_a_q   <= in_a;
          s1_b_q   <= in_b;
          s1_tag_q <= in_tag;
          s1_ca_q  <= classify(in_a);
          s1_cb_q  <= classify(in_b);
        end
      end
      if (s2_en) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_result_q <= s2_result_d;
          s2_tag_q    <= s1_tag_q;
          s2_nv_q     <= s2_nv_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_fcmp_pipe.sv
// tb_fcmp_pipe: directed vectors for fcmp_pipe; expected results queued at accept, checked by a monitor.
// Compile with FCMP_FCLASS_EN to match an RTL built with FCLASS.
module tb_fcmp_pipe;

  localparam logic [2:0] FMAX = 3'b000, FMIN = 3'b001, FEQ = 3'b010,
                         FLT = 3'b011, FLE = 3'b100, FCLS = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        out_nv;

  fcmp_pipe #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_nv(out_nv)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        nv;
    logic [4:0]  tag;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [4:0] tag_cnt = 5'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: mid-low-phase sample; while stalled the head entry must stay on the outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got tag %0d result %08h expected none", out_tag, out_result);
        end else begin
          e = sb[0];
          check($sformatf("result tag%0d", e.tag), out_result, e.res);
          check($sformatf("nv tag%0d", e.tag), {31'd0, out_nv}, {31'd0, e.nv});
          check($sformatf("tag tag%0d", e.tag), {27'd0, out_tag}, {27'd0, e.tag});
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic nv);
    int guard;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag_cnt;
    #1;
    guard = 0;
    while (!in_ready) begin
      guard++;
      if (guard > 100) begin
        $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles expected accept", guard);
        $fatal(1, "input stalled");
      end
      @(negedge clk);
      #1;
    end
    e.res = res;
    e.nv  = nv;
    e.tag = tag_cnt;
    sb.push_back(e);
    tag_cnt = tag_cnt + 5'd1;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d results outstanding expected 0", sb.size());
      sb.delete();
    end
  endtask

  logic [31:0] cls_ninf, cls_qnan, cls_psub, cls_nzero, cls_snan;

  initial begin
`ifdef FCMP_FCLASS_EN
    cls_ninf = 32'h001; cls_qnan = 32'h200; cls_psub = 32'h020; cls_nzero = 32'h008; cls_snan = 32'h100;
`else
    cls_ninf = 32'h0; cls_qnan = 32'h0; cls_psub = 32'h0; cls_nzero = 32'h0; cls_snan = 32'h0;
`endif
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    #12;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out_result", out_result, 32'd0);
    check("reset out_tag", {27'd0, out_tag}, 32'd0);
    check("reset out_nv", {31'd0, out_nv}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Signed zeros, NaN propagation, basic compares.
    send(FMAX, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0);
    send(FMIN, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0);
    send(FMIN, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0);
    send(FMAX, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
    send(FMIN, 32'h7F80_0001, 32'h3F80_0000, 32'h3F80_0000, 1'b1);
    send(FMAX, 32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000, 1'b0);
    send(FMIN, 32'h7FC0_0000, 32'h7F80_0001, 32'h7FC0_0000, 1'b1);
    send(FMAX, 32'h7FC0_0000, 32'hBF80_0000, 32'hBF80_0000, 1'b0);
    send(FMAX, 32'hBF80_0000, 32'hC000_0000, 32'hBF80_0000, 1'b0);
    send(FMIN, 32'hBF80_0000, 32'hC000_0000, 32'hC000_0000, 1'b0);
    send(FMIN, 32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 1'b0);
    send(FMAX, 32'h3F80_0000, 32'hC000_0000, 32'h3F80_0000, 1'b0);
    send(FMIN, 32'h0080_0000, 32'h0000_0001, 32'h0000_0001, 1'b0);
    send(FLT,  32'h7FC0_0000, 32'h0000_0000, 32'h0, 1'b1);
    send(FEQ,  32'h7FC0_0000, 32'h0000_0000, 32'h0, 1'b0);
    send(FLE,  32'hC000_0000, 32'hBF80_0000, 32'h1, 1'b0);
    send(FEQ,  32'h0000_0000, 32'h8000_0000, 32'h1, 1'b0);
    send(FEQ,  32'h7F80_0001, 32'h7F80_0001, 32'h0, 1'b1);
    send(FEQ,  32'h3F80_0000, 32'h3F80_0000, 32'h1, 1'b0);
    send(FEQ,  32'h3F80_0000, 32'h4000_0000, 32'h0, 1'b0);
    send(FLT,  32'h3F80_0000, 32'h4000_0000, 32'h1, 1'b0);
    send(FLT,  32'h4000_0000, 32'h4000_0000, 32'h0, 1'b0);
    send(FLE,  32'h4000_0000, 32'h4000_0000, 32'h1, 1'b0);
    send(FLE,  32'h4000_0000, 32'h3F80_0000, 32'h0, 1'b0);
    send(FLT,  32'h8000_0000, 32'h0000_0000, 32'h0, 1'b0);
    send(FLE,  32'h8000_0000, 32'h0000_0000, 32'h1, 1'b0);
    send(FLE,  32'h0000_0000, 32'h7FC0_0000, 32'h0, 1'b1);
    send(FLT,  32'hFF80_0000, 32'h7F80_0000, 32'h1, 1'b0);
    send(FLT,  32'hBF80_0000, 32'hC000_0000, 32'h0, 1'b0);
    send(3'b110, 32'h3F80_0000, 32'h4000_0000, 32'h0, 1'b0);
    send(3'b111, 32'h7F80_0001, 32'h7F80_0001, 32'h0, 1'b0);
    send(FCLS, 32'hFF80_0000, 32'h0, cls_ninf, 1'b0);
    send(FCLS, 32'h7FC0_0000, 32'h0, cls_qnan, 1'b0);
    send(FCLS, 32'h0000_0001, 32'h0, cls_psub, 1'b0);
    send(FCLS, 32'h8000_0000, 32'h0, cls_nzero, 1'b0);
    send(FCLS, 32'h7F80_0001, 32'h0, cls_snan, 1'b0);
    idle();
    drain();

    // Backpressure: four back-to-back ops, output stalled for three cycles.
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        send(FMAX, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0);
        send(FMIN, 32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
        send(FLT,  32'h3F80_0000, 32'h4000_0000, 32'h1, 1'b0);
        send(FEQ,  32'h7F80_0001, 32'h3F80_0000, 32'h0, 1'b1);
        idle();
      end
      begin
        repeat (3) @(negedge clk);
        #1;
        check("stall in_ready", {31'd0, in_ready}, 32'd0);
        check("stall out_valid", {31'd0, out_valid}, 32'd1);
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two ops in flight: both are discarded.
    send(FMAX, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 1'b0);
    send(FMIN, 32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 1'b0);
    idle();
    #1;
    rst = 1'b1;
    #1;
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst out_result", out_result, 32'd0);
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post-rst out_valid", {31'd0, out_valid}, 32'd0);

    send(FLE, 32'hC000_0000, 32'hC000_0000, 32'h1, 1'b0);
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
